// File: rtl/firebird_ifetch.sv
// firebird_ifetch: single-outstanding instruction fetch stage with a one-entry output buffer
// and redirect flush that drops stale memory responses.
module firebird_ifetch #(
  parameter int PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                clk,
  input  logic                ifu_reset_n,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [PC_WIDTH-1:0] imem_rdata,
  input  logic                imem_err,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [PC_WIDTH-1:0] inst_data,
  output logic [PC_WIDTH-1:0] inst_pc,
  output logic                inst_fault
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_n;
  logic [PC_WIDTH-1:0] fetch_pc, fetch_pc_n, addr_n, data_n, pc_n;
  logic drop, drop_n, valid_n, fault_n;
  always_comb begin
    state_n = state;
    fetch_pc_n = fetch_pc;
    addr_n = imem_addr;
    drop_n = drop;
    valid_n = inst_valid && !inst_ready;
    data_n = inst_data;
    pc_n = inst_pc;
    fault_n = inst_fault;
    case (state)
      IDLE: if (!redirect_valid && (!inst_valid || inst_ready)) begin
        state_n = REQ;
        addr_n = fetch_pc;
      end
      REQ: begin
        if (imem_gnt) state_n = WAIT;
        if (redirect_valid) drop_n = 1'b1;
      end
      WAIT: if (imem_rvalid) begin
        state_n = IDLE;
        drop_n = 1'b0;
        if (!drop && !redirect_valid) begin
          data_n = imem_rdata;
          pc_n = imem_addr;
          fault_n = imem_err;
          valid_n = 1'b1;
          fetch_pc_n = fetch_pc + PC_WIDTH'(4);
        end
      end else if (redirect_valid) drop_n = 1'b1;
      default: state_n = IDLE;
    endcase
    // flush overrides any load or handshake in the same cycle
    if (redirect_valid) begin
      fetch_pc_n = redirect_pc & ~PC_WIDTH'(3);
      valid_n = 1'b0;
      fault_n = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge ifu_reset_n) begin
    if (!ifu_reset_n) begin
      state <= IDLE;
      fetch_pc <= RESET_ADDR;
      imem_addr <= RESET_ADDR;
      drop <= 1'b0;
      imem_req <= 1'b0;
      inst_valid <= 1'b0;
      inst_data <= '0;
      inst_pc <= '0;
      inst_fault <= 1'b0;
    end else begin
      state <= state_n;
      fetch_pc <= fetch_pc_n;
      imem_addr <= addr_n;
      drop <= drop_n;
      imem_req <= state_n == REQ;
      inst_valid <= valid_n;
      inst_data <= data_n;
      inst_pc <= pc_n;
      inst_fault <= fault_n;
    end
  end
endmodule

// File: tb/tb_firebird_ifetch.sv
// tb_firebird_ifetch: directed vector table, corner sequences and randomized run checked
// against a fetch-order reference model.
module tb_firebird_ifetch;
  logic clk = 0, rst_n = 0, redirect_valid = 0, imem_gnt = 0, imem_rvalid = 0, imem_err = 0, inst_ready = 0;
  logic [31:0] redirect_pc = 0, imem_rdata = 0;
  logic imem_req, inst_valid, inst_fault;
  logic [31:0] imem_addr, inst_data, inst_pc;
  logic rst2_n = 0, redir2 = 0, gnt2 = 0, rvalid2 = 0, err2 = 0, ready2 = 1;
  logic [31:0] rpc2 = 0, rdata2 = 0;
  logic req2, valid2, fault2;
  logic [31:0] addr2, data2, pc2;
  int passed = 0, total = 0, gnt_pct = 100, max_lat = 0;

  always #5 clk = ~clk;

  firebird_ifetch dut (.clk(clk), .ifu_reset_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .imem_err(imem_err), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .inst_fault(inst_fault));

  firebird_ifetch #(.RESET_ADDR(32'hFFFF_FFFC)) dut2 (.clk(clk), .ifu_reset_n(rst2_n), .redirect_valid(redir2),
    .redirect_pc(rpc2), .imem_req(req2), .imem_addr(addr2), .imem_gnt(gnt2), .imem_rvalid(rvalid2),
    .imem_rdata(rdata2), .imem_err(err2), .inst_valid(valid2), .inst_ready(ready2),
    .inst_data(data2), .inst_pc(pc2), .inst_fault(fault2));

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return a[7:2] == 6'h10;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", n, act, exp);
    else passed++;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(negedge clk); #3;
      ok = inst_valid;
    end
  endtask

  task automatic wait_req(output bit ok, output bit stale);
    ok = 0;
    stale = 0;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(negedge clk); #3;
      if (inst_valid) stale = 1;
      ok = imem_req;
    end
  endtask

  // memory for dut: grant with probability gnt_pct, respond 1+random(0..max_lat) cycles after grant
  initial begin
    logic pend;
    logic [31:0] gaddr, paddr;
    int lat;
    pend = 0; gaddr = 0; paddr = 0; lat = 0;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        pend = 0; imem_gnt = 0; imem_rvalid = 0; imem_err = 0;
      end else begin
        if (imem_gnt) begin pend = 1; paddr = gaddr; lat = $urandom_range(0, max_lat); end
        imem_rvalid = 0;
        imem_rdata = $urandom;
        imem_err = 1'($urandom);
        if (pend) begin
          if (lat == 0) begin
            imem_rvalid = 1; imem_rdata = mem_data(paddr); imem_err = mem_err(paddr); pend = 0;
          end else lat--;
        end
        imem_gnt = imem_req && ($urandom_range(1, 100) <= gnt_pct);
        if (imem_gnt) gaddr = imem_addr;
      end
    end
  end

  // memory for dut2: gnt tied to req, response exactly one cycle after grant
  initial begin
    logic [31:0] ga2;
    ga2 = 0;
    forever begin
      @(negedge clk); #1;
      if (!rst2_n) begin
        gnt2 = 0; rvalid2 = 0;
      end else begin
        rvalid2 = gnt2; rdata2 = mem_data(ga2); err2 = mem_err(ga2);
        gnt2 = req2; ga2 = addr2;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic ready, redir;
    logic [31:0] rpc;
    logic req;
    logic [31:0] addr;
    logic valid;
    logic [31:0] pc;
  } vec_t;

  initial begin
    vec_t tbl[16];
    bit ok, stale, prev_stall;
    logic [31:0] exp_pc, prev_addr;
    int hs;
    tbl[0]  = '{1, 0, 0,       0, 0,      0, 0};
    tbl[1]  = '{1, 0, 0,       1, 0,      0, 0};
    tbl[2]  = '{1, 0, 0,       0, 0,      0, 0};
    tbl[3]  = '{0, 0, 0,       0, 0,      1, 0};
    tbl[4]  = '{0, 0, 0,       0, 0,      1, 0};
    tbl[5]  = '{0, 0, 0,       0, 0,      1, 0};
    tbl[6]  = '{1, 0, 0,       0, 0,      1, 0};
    tbl[7]  = '{1, 0, 0,       1, 4,      0, 0};
    tbl[8]  = '{1, 0, 0,       0, 4,      0, 0};
    tbl[9]  = '{1, 0, 0,       0, 4,      1, 4};
    tbl[10] = '{1, 0, 0,       1, 8,      0, 0};
    tbl[11] = '{1, 1, 32'h103, 0, 8,      0, 0};
    tbl[12] = '{1, 0, 0,       0, 8,      0, 0};
    tbl[13] = '{1, 0, 0,       1, 32'h100, 0, 0};
    tbl[14] = '{1, 0, 0,       0, 32'h100, 0, 0};
    tbl[15] = '{1, 0, 0,       0, 32'h100, 1, 32'h100};

    #12;
    chk("rst req", imem_req, 0);
    chk("rst addr", imem_addr, 0);
    chk("rst valid", inst_valid, 0);
    chk("rst data", inst_data, 0);
    chk("rst pc", inst_pc, 0);
    chk("rst fault", inst_fault, 0);
    chk("rst2 addr", addr2, 32'hFFFF_FFFC);

    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      inst_ready = tbl[i].ready;
      redirect_valid = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
      #3;
      chk($sformatf("vec%0d req", i), imem_req, tbl[i].req);
      chk($sformatf("vec%0d addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("vec%0d valid", i), inst_valid, tbl[i].valid);
      if (tbl[i].valid) begin
        chk($sformatf("vec%0d pc", i), inst_pc, tbl[i].pc);
        chk($sformatf("vec%0d data", i), inst_data, mem_data(tbl[i].pc));
        chk($sformatf("vec%0d fault", i), inst_fault, 0);
      end
    end

    // grant withheld while a redirect arrives
    @(negedge clk);
    redirect_valid = 0; inst_ready = 1; gnt_pct = 0;
    #3 chk("hold req", imem_req, 1);
    chk("hold addr", imem_addr, 32'h104);
    @(negedge clk);
    redirect_valid = 1; redirect_pc = 32'h200;
    #3 chk("hold redir addr", imem_addr, 32'h104);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      redirect_valid = 0;
      #3 chk($sformatf("hold%0d req", k), imem_req, 1);
      chk($sformatf("hold%0d addr", k), imem_addr, 32'h104);
    end
    @(negedge clk);
    gnt_pct = 100;
    #3;
    wait_req(ok, stale);
    chk("redir req seen", ok, 1);
    chk("stale dropped", stale, 0);
    chk("redir addr", imem_addr, 32'h200);
    wait_valid(ok);
    chk("redir valid", ok, 1);
    chk("redir pc", inst_pc, 32'h200);
    chk("redir data", inst_data, mem_data(32'h200));

    // errored response is delivered with its data, fetch continues sequentially
    @(negedge clk);
    redirect_valid = 1; redirect_pc = 32'h41;
    @(negedge clk);
    redirect_valid = 0;
    wait_valid(ok);
    chk("err valid", ok, 1);
    chk("err pc", inst_pc, 32'h40);
    chk("err fault", inst_fault, 1);
    chk("err data", inst_data, mem_data(32'h40));
    wait_req(ok, stale);
    chk("err next addr", imem_addr, 32'h44);
    wait_valid(ok);
    chk("err next pc", inst_pc, 32'h44);
    chk("err next fault", inst_fault, 0);

    // top-of-memory reset address wraps, then asynchronous reset during a request
    @(negedge clk);
    rst2_n = 1;
    #3 chk("wrap s0 req", req2, 0);
    @(negedge clk); #3;
    chk("wrap s1 req", req2, 1);
    chk("wrap s1 addr", addr2, 32'hFFFF_FFFC);
    @(negedge clk); #3;
    @(negedge clk); #3;
    chk("wrap s3 valid", valid2, 1);
    chk("wrap s3 pc", pc2, 32'hFFFF_FFFC);
    chk("wrap s3 data", data2, mem_data(32'hFFFF_FFFC));
    @(negedge clk); #3;
    chk("wrap s4 req", req2, 1);
    chk("wrap s4 addr", addr2, 0);
    rst2_n = 0;
    #1 chk("async rst req", req2, 0);
    chk("async rst addr", addr2, 32'hFFFF_FFFC);
    chk("async rst valid", valid2, 0);

    // randomized run against the fetch-order model
    @(negedge clk);
    rst_n = 0; redirect_valid = 0;
    @(negedge clk);
    #3 chk("rerst valid", inst_valid, 0);
    chk("rerst req", imem_req, 0);
    gnt_pct = 50; max_lat = 2;
    exp_pc = 0; hs = 0; prev_stall = 0; prev_addr = 0;
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) @(negedge clk);
      inst_ready = $urandom_range(0, 9) < 7;
      redirect_valid = $urandom_range(0, 19) == 0;
      redirect_pc = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom_range(0, 1023));
      #3;
      if (prev_stall) begin
        chk("rnd req hold", imem_req, 1);
        chk("rnd addr hold", imem_addr, prev_addr);
      end
      if (imem_req) chk("rnd req while full", inst_valid, 0);
      if (inst_valid && inst_ready && !redirect_valid) begin
        chk("rnd pc", inst_pc, exp_pc);
        chk("rnd data", inst_data, mem_data(exp_pc));
        chk("rnd fault", inst_fault, mem_err(exp_pc));
        exp_pc += 4;
        hs++;
      end
      if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
      prev_stall = imem_req && !imem_gnt;
      prev_addr = imem_addr;
    end
    chk("rnd progress", hs >= 100, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
